ghost_dir_picker: RTL and testbench

//  Consumes the free-running 10-bit pseudo-random word from the LFSR and turns it into a legal,
//  non-reversing move direction for one ghost at a maze intersection.

---
 rtl/ghost_dir_picker.sv | 120 ++++++++++++
 tb/tb_ghost_dir_picker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ghost_dir_picker.sv
// Picks a legal, non-reversing ghost direction from an LFSR word.
// One candidate direction is tested per cycle; the result is held until the consumer takes it.
module ghost_dir_picker #(
    parameter int RND_W      = 10,
    parameter int PICK_CNT_W = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [RND_W-1:0]      rnd_in,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            allowed_mask,
    input  logic [1:0]            cur_dir,
    output logic                  dir_valid,
    input  logic                  dir_ready,
    output logic [1:0]            dir,
    output logic                  no_move,
    output logic [PICK_CNT_W-1:0] pick_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            mask_q, mask_d;
    logic [1:0]            start_q, start_d;
    logic                  step_dn_q, step_dn_d;
    logic [1:0]            k_q, k_d;
    logic [1:0]            dir_q, dir_d;
    logic                  no_move_q, no_move_d;
    logic [PICK_CNT_W-1:0] pick_q, pick_d;

    logic [1:0] rev;
    logic [3:0] no_rev_mask;
    logic [3:0] eff_mask;
    logic [1:0] cand;
    logic       unused_rnd;

    // Only the low three LFSR bits steer the pick.
    assign unused_rnd = ^rnd_in;

    // A dead end leaves only the reverse direction, so reversal is allowed there.
    assign rev         = cur_dir ^ 2'd2;
    assign no_rev_mask = allowed_mask & ~(4'd1 << rev);
    assign eff_mask    = (no_rev_mask != 4'd0) ? no_rev_mask : allowed_mask;
    assign cand        = step_dn_q ? (start_q - k_q) : (start_q + k_q);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        start_d   = start_q;
        step_dn_d = step_dn_q;
        k_d       = k_q;
        dir_d     = dir_q;
        no_move_d = no_move_q;
        pick_d    = pick_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mask_d    = eff_mask;
                    start_d   = rnd_in[1:0];
                    step_dn_d = rnd_in[2];
                    k_d       = 2'd0;
                    if (eff_mask == 4'd0) begin
                        dir_d     = cur_dir;
                        no_move_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        no_move_d = 1'b0;
                        state_d   = SCAN;
                    end
                end
            end
            SCAN: begin
                if (mask_q[cand]) begin
                    dir_d     = cand;
                    no_move_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DONE: begin
                if (dir_ready) begin
                    pick_d  = pick_q + PICK_CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            mask_q    <= 4'd0;
            start_q   <= 2'd0;
            step_dn_q <= 1'b0;
            k_q       <= 2'd0;
            dir_q     <= 2'd0;
            no_move_q <= 1'b0;
            pick_q    <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            start_q   <= start_d;
            step_dn_q <= step_dn_d;
            k_q       <= k_d;
            dir_q     <= dir_d;
            no_move_q <= no_move_d;
            pick_q    <= pick_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign dir_valid  = (state_q == DONE);
    assign dir        = dir_q;
    assign no_move    = no_move_q;
    assign pick_count = pick_q;

endmodule

// File: tb/tb_ghost_dir_picker.sv
// Directed bench for ghost_dir_picker; pick counter narrowed to 3 bits to reach its wrap quickly.
module tb_ghost_dir_picker;

    localparam int RW  = 10;
    localparam int PCW = 3;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic [RW-1:0]  rnd_in = '0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [3:0]     allowed_mask = 4'd0;
    logic [1:0]     cur_dir = 2'd0;
    logic           dir_valid;
    logic           dir_ready = 1'b0;
    logic [1:0]     dir;
    logic           no_move;
    logic [PCW-1:0] pick_count;

    int             n_checks = 0;
    int             n_fail = 0;
    logic [PCW-1:0] exp_cnt = '0;

    ghost_dir_picker #(.RND_W(RW), .PICK_CNT_W(PCW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .rnd_in(rnd_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .allowed_mask(allowed_mask), .cur_dir(cur_dir),
        .dir_valid(dir_valid), .dir_ready(dir_ready),
        .dir(dir), .no_move(no_move), .pick_count(pick_count)
    );

    always #5 Clk = ~Clk;

    // Issue one request; lat = clock edges after the accept edge until dir_valid (99 on timeout).
    task automatic issue(input logic [3:0] m, input logic [1:0] cd, input logic [RW-1:0] r,
                         output int lat);
        allowed_mask = m; cur_dir = cd; rnd_in = r; req_valid = 1'b1;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        allowed_mask = ~m; cur_dir = ~cd; rnd_in = ~r;
        lat = 0;
        while (!dir_valid && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        if (!dir_valid) lat = 99;
    endtask

    task automatic release_pick();
        dir_ready = 1'b1;
        @(posedge Clk); #1;
        dir_ready = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || dir_valid !== 1'b0 || dir !== 2'd0 || no_move !== 1'b0 || pick_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset: rr=%b dv=%b dir=%0d nm=%b cnt=%0d, want 1 0 0 0 0",
                     req_ready, dir_valid, dir, no_move, pick_count);
        end
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        exp_cnt = '0;
    endtask

    task automatic test_pick(input string nm, input logic [3:0] m, input logic [1:0] cd,
                             input logic [RW-1:0] r, input logic [1:0] e_dir,
                             input logic e_nm, input int e_lat);
        int lat;
        issue(m, cd, r, lat);
        n_checks++;
        if (lat !== e_lat || dir !== e_dir || no_move !== e_nm || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: lat=%0d dir=%0d nm=%b rr=%b, want lat=%0d dir=%0d nm=%b rr=0",
                     nm, lat, dir, no_move, req_ready, e_lat, e_dir, e_nm);
        end
        release_pick();
        n_checks++;
        if (pick_count !== exp_cnt || req_ready !== 1'b1 || dir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: cnt=%0d rr=%b dv=%b, want cnt=%0d rr=1 dv=0",
                     nm, pick_count, req_ready, dir_valid, exp_cnt);
        end
    endtask

    task automatic test_stall();
        int lat;
        issue(4'b1010, 2'd3, 10'h004, lat);
        req_valid = 1'b1; allowed_mask = 4'b0000; cur_dir = 2'd0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (dir_valid !== 1'b1 || dir !== 2'd3 || no_move !== 1'b0 || req_ready !== 1'b0 || pick_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL stall_%0d: dv=%b dir=%0d nm=%b rr=%b cnt=%0d, want 1 3 0 0 %0d",
                         i, dir_valid, dir, no_move, req_ready, pick_count, exp_cnt);
            end
            @(posedge Clk); #1;
        end
        req_valid = 1'b0;
        release_pick();
        n_checks++;
        if (pick_count !== exp_cnt || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: cnt=%0d rr=%b, want %0d 1", pick_count, req_ready, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(4'b0000, 2'd1, 10'h000, lat);
        allowed_mask = 4'b0000; cur_dir = 2'd2; req_valid = 1'b1; dir_ready = 1'b1;
        @(posedge Clk); #1;
        dir_ready = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        n_checks++;
        if (req_ready !== 1'b1 || dir_valid !== 1'b0 || pick_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_gap: rr=%b dv=%b cnt=%0d, want 1 0 %0d", req_ready, dir_valid, pick_count, exp_cnt);
        end
        @(posedge Clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (dir_valid !== 1'b1 || dir !== 2'd2 || no_move !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: dv=%b dir=%0d nm=%b, want 1 2 1", dir_valid, dir, no_move);
        end
        release_pick();
    endtask

    task automatic test_wrap();
        int lat;
        for (int i = 0; i < 9; i++) begin
            issue(4'b0000, 2'd0, 10'h000, lat);
            release_pick();
            n_checks++;
            if (pick_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL wrap_%0d: cnt=%0d, want %0d", i, pick_count, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        allowed_mask = 4'b1111; cur_dir = 2'd0; rnd_in = 10'h002; req_valid = 1'b1;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        @(posedge Clk); #1;
        n_checks++;
        if (dir_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midscan_busy: dv=%b rr=%b, want 0 0", dir_valid, req_ready);
        end
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || dir_valid !== 1'b0 || pick_count !== 3'd0 || dir !== 2'd0) begin
            n_fail++;
            $display("FAIL midscan_reset: rr=%b dv=%b cnt=%0d dir=%0d, want 1 0 0 0",
                     req_ready, dir_valid, pick_count, dir);
        end
        exp_cnt = '0;
        #2 Reset_n = 1'b1;
        @(posedge Clk); #1;
        test_pick("after_reset", 4'b1111, 2'd0, 10'h002, 2'd3, 1'b0, 2);
    endtask

    initial begin
        test_reset();
        test_pick("case1_rev_skip", 4'b1111, 2'd0, 10'h002, 2'd3, 1'b0, 2);
        test_pick("case2_dead_end", 4'b0100, 2'd0, 10'h000, 2'd2, 1'b0, 3);
        test_pick("case3_no_move",  4'b0000, 2'd1, 10'h155, 2'd1, 1'b1, 0);
        test_pick("case4_step_dn",  4'b1010, 2'd3, 10'h004, 2'd3, 1'b0, 2);
        test_pick("down_wrap",      4'b0011, 2'd2, 10'h3FF, 2'd1, 1'b0, 3);
        test_pick("first_hit",      4'b0010, 2'd0, 10'h001, 2'd1, 1'b0, 1);
        test_stall();
        test_back_to_back();
        test_wrap();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
